// File: rtl/seq_pkg.sv
// Shared state encoding and RV32I major-opcode constants for the multi-cycle sequencer.
package seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_TRAP   = 3'd7
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // SYSTEM is deliberately not "legal" here: DECODE routes it to HALT first.
  function automatic logic is_legal_op(input logic [6:0] op);
    logic legal;
    case (op)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: legal = 1'b1;
      default:                           legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive stalled memory cycles; flags expiry on the last allowed stall cycle.
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic ready,
  output logic expired
);

  generate
    if (MEM_TIMEOUT == 0) begin : g_off
      assign expired = 1'b0;
    end else begin : g_on
      localparam int unsigned    TW   = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
      localparam logic [TW-1:0] LAST = TW'(MEM_TIMEOUT - 1);

      logic [TW-1:0] cnt_q, cnt_d;
      logic          stall;

      // Any cycle that is not a stall (ready, or outside FETCH/MEM) restarts the count.
      always_comb begin
        stall   = active && !ready;
        expired = stall && (cnt_q == LAST);
        cnt_d   = '0;
        if (stall && !expired) cnt_d = cnt_q + 1'b1;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
      end
    end
  endgenerate

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB controller over one shared memory port.
// Optional performance counters are built when SEQ_PERF_CNT_EN is defined.
module multicycle_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [6:0]       opcode,
  input  logic             dec_ruwr,
  input  logic             dec_dmwr,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_sel,
  output logic             mem_we,
  output logic             ir_we,
  output logic             pc_we,
  output logic             ru_we,
  output logic [2:0]       stage,
  output logic             halted,
  output logic             trap,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret
);

  state_e state_q, state_d;
  state_e after_retire;
  logic   wait_active;
  logic   wait_expired;

  assign wait_active  = (state_q == S_FETCH) || (state_q == S_MEM);
  assign after_retire = run ? S_FETCH : S_IDLE;

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wait_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .active (wait_active),
    .ready  (mem_ready),
    .expired(wait_expired)
  );

  always_comb begin
    state_d = state_q;
    mem_req = 1'b0;
    mem_sel = 1'b0;
    mem_we  = 1'b0;
    ir_we   = 1'b0;
    pc_we   = 1'b0;
    ru_we   = 1'b0;
    halted  = 1'b0;
    trap    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else if (wait_expired) begin
          state_d = S_TRAP;
        end
      end
      S_DECODE: begin
        if (opcode == OP_SYSTEM)      state_d = S_HALT;
        else if (!is_legal_op(opcode)) state_d = S_TRAP;
        else                          state_d = S_EXEC;
      end
      S_EXEC: begin
        if (opcode == OP_LOAD || opcode == OP_STORE) begin
          state_d = S_MEM;
        end else if (opcode == OP_BRANCH) begin
          pc_we   = 1'b1;
          state_d = after_retire;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_sel = 1'b1;
        mem_we  = dec_dmwr;
        if (mem_ready) begin
          if (opcode == OP_STORE) begin
            pc_we   = 1'b1;
            state_d = after_retire;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_expired) begin
          state_d = S_TRAP;
        end
      end
      S_WB: begin
        ru_we   = dec_ruwr;
        pc_we   = 1'b1;
        state_d = after_retire;
      end
      S_HALT:  halted = 1'b1;
      S_TRAP:  trap   = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  assign stage = state_q;

`ifdef SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  // pc_we fires exactly once per instruction, so it doubles as the retire strobe.
  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    instret_d   = instret_q;
    if (state_q != S_IDLE && state_q != S_HALT && state_q != S_TRAP)
      cycle_cnt_d = cycle_cnt_q + 1'b1;
    if (pc_we)
      instret_d = instret_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_q <= '0;
      instret_q   <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      instret_q   <= instret_d;
    end
  end

  assign cycle_cnt = cycle_cnt_q;
  assign instret   = instret_q;
`else
  assign cycle_cnt = '0;
  assign instret   = '0;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed table-driven bench for multicycle_sequencer plus hand-written timeout/halt/trap/reset sequences.
module tb_multicycle_sequencer;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_SYS = 7'b1110011;
  localparam logic [6:0] OP_BAD = 7'b0000000;

  // outs = {mem_req, mem_sel, mem_we, ir_we, pc_we, ru_we, halted, trap}
  typedef struct {
    logic       run;
    logic [6:0] op;
    logic       ruwr;
    logic       dmwr;
    logic       rdy;
    logic [2:0] stg;
    logic [7:0] outs;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic [6:0]  opcode = '0;
  logic        dec_ruwr = 1'b0;
  logic        dec_dmwr = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_sel, mem_we, ir_we, pc_we, ru_we, halted, trap;
  logic [2:0]  stage;
  logic [31:0] cycle_cnt, instret;

  int errs = 0;
  int checks = 0;
  vec_t tbl [25];

  always #5 clk = ~clk;

  multicycle_sequencer #(
    .MEM_TIMEOUT(8),
    .CNT_W      (32)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .opcode   (opcode),
    .dec_ruwr (dec_ruwr),
    .dec_dmwr (dec_dmwr),
    .mem_ready(mem_ready),
    .mem_req  (mem_req),
    .mem_sel  (mem_sel),
    .mem_we   (mem_we),
    .ir_we    (ir_we),
    .pc_we    (pc_we),
    .ru_we    (ru_we),
    .stage    (stage),
    .halted   (halted),
    .trap     (trap),
    .cycle_cnt(cycle_cnt),
    .instret  (instret)
  );

  function automatic vec_t mk(input logic r, input logic [6:0] op, input logic ruwr,
                              input logic dmwr, input logic rdy, input logic [2:0] stg,
                              input logic [7:0] o);
    vec_t v;
    v.run = r; v.op = op; v.ruwr = ruwr; v.dmwr = dmwr; v.rdy = rdy; v.stg = stg; v.outs = o;
    return v;
  endfunction

  function automatic logic [7:0] obs_outs();
    return {mem_req, mem_sel, mem_we, ir_we, pc_we, ru_we, halted, trap};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end else begin
      $display("ok   %s: %0h", nm, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_counters(input string nm, input logic [31:0] exp_cyc, input logic [31:0] exp_ret);
`ifdef SEQ_PERF_CNT_EN
    chk({nm, "_cycle_cnt"}, cycle_cnt, exp_cyc);
    chk({nm, "_instret"}, instret, exp_ret);
`else
    chk({nm, "_cycle_cnt"}, cycle_cnt, 32'd0 & exp_cyc);
    chk({nm, "_instret"}, instret, 32'd0 & exp_ret);
`endif
  endtask

  task automatic do_reset(input string nm);
    rst_n = 1'b0; run = 1'b0; opcode = '0; dec_ruwr = 1'b0; dec_dmwr = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk({nm, "_rst_stage"}, {29'd0, stage}, 32'd0);
    chk({nm, "_rst_outs"}, {24'd0, obs_outs()}, 32'd0);
    chk_counters({nm, "_rst"}, 32'd0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    tbl[0]  = mk(1'b1, OP_R,   1'b1, 1'b0, 1'b1, 3'd0, 8'b0000_0000);
    tbl[1]  = mk(1'b1, OP_R,   1'b1, 1'b0, 1'b1, 3'd1, 8'b1001_0000);
    tbl[2]  = mk(1'b1, OP_R,   1'b1, 1'b0, 1'b1, 3'd2, 8'b0000_0000);
    tbl[3]  = mk(1'b1, OP_R,   1'b1, 1'b0, 1'b1, 3'd3, 8'b0000_0000);
    tbl[4]  = mk(1'b1, OP_R,   1'b1, 1'b0, 1'b1, 3'd5, 8'b0000_1100);
    tbl[5]  = mk(1'b1, OP_LD,  1'b1, 1'b0, 1'b1, 3'd1, 8'b1001_0000);
    tbl[6]  = mk(1'b1, OP_LD,  1'b1, 1'b0, 1'b1, 3'd2, 8'b0000_0000);
    tbl[7]  = mk(1'b1, OP_LD,  1'b1, 1'b0, 1'b1, 3'd3, 8'b0000_0000);
    tbl[8]  = mk(1'b1, OP_LD,  1'b1, 1'b0, 1'b0, 3'd4, 8'b1100_0000);
    tbl[9]  = mk(1'b1, OP_LD,  1'b1, 1'b0, 1'b0, 3'd4, 8'b1100_0000);
    tbl[10] = mk(1'b1, OP_LD,  1'b1, 1'b0, 1'b1, 3'd4, 8'b1100_0000);
    tbl[11] = mk(1'b1, OP_LD,  1'b1, 1'b0, 1'b1, 3'd5, 8'b0000_1100);
    tbl[12] = mk(1'b1, OP_ST,  1'b0, 1'b1, 1'b1, 3'd1, 8'b1001_0000);
    tbl[13] = mk(1'b1, OP_ST,  1'b0, 1'b1, 1'b1, 3'd2, 8'b0000_0000);
    tbl[14] = mk(1'b0, OP_ST,  1'b0, 1'b1, 1'b1, 3'd3, 8'b0000_0000);
    tbl[15] = mk(1'b0, OP_ST,  1'b0, 1'b1, 1'b1, 3'd4, 8'b1110_1000);
    tbl[16] = mk(1'b0, OP_ST,  1'b0, 1'b1, 1'b1, 3'd0, 8'b0000_0000);
    tbl[17] = mk(1'b1, OP_BR,  1'b0, 1'b0, 1'b1, 3'd0, 8'b0000_0000);
    tbl[18] = mk(1'b1, OP_BR,  1'b0, 1'b0, 1'b1, 3'd1, 8'b1001_0000);
    tbl[19] = mk(1'b1, OP_BR,  1'b0, 1'b0, 1'b1, 3'd2, 8'b0000_0000);
    tbl[20] = mk(1'b1, OP_BR,  1'b0, 1'b0, 1'b1, 3'd3, 8'b0000_1000);
    tbl[21] = mk(1'b1, OP_JAL, 1'b1, 1'b0, 1'b1, 3'd1, 8'b1001_0000);
    tbl[22] = mk(1'b1, OP_JAL, 1'b1, 1'b0, 1'b1, 3'd2, 8'b0000_0000);
    tbl[23] = mk(1'b1, OP_JAL, 1'b1, 1'b0, 1'b1, 3'd3, 8'b0000_0000);
    tbl[24] = mk(1'b1, OP_JAL, 1'b1, 1'b0, 1'b1, 3'd5, 8'b0000_1100);

    // Table: R-type, load with two stall cycles, store with run dropped, branch, jal.
    do_reset("tbl");
    for (int i = 0; i < 25; i++) begin
      run = tbl[i].run; opcode = tbl[i].op; dec_ruwr = tbl[i].ruwr;
      dec_dmwr = tbl[i].dmwr; mem_ready = tbl[i].rdy;
      @(negedge clk);
      chk($sformatf("vec%0d_stage", i), {29'd0, stage}, {29'd0, tbl[i].stg});
      chk($sformatf("vec%0d_outs", i), {24'd0, obs_outs()}, {24'd0, tbl[i].outs});
      step();
    end
    chk_counters("tbl_end", 32'd22, 32'd5);

    // Fetch stall until timeout: 8 wait cycles then TRAP, IR never loaded.
    do_reset("tmo");
    run = 1'b1; opcode = OP_R; mem_ready = 1'b0;
    step();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("tmo_wait%0d_stage", i), {29'd0, stage}, 32'd1);
      chk($sformatf("tmo_wait%0d_ir_we", i), {31'd0, ir_we}, 32'd0);
      step();
    end
    chk("tmo_stage", {29'd0, stage}, 32'd7);
    chk("tmo_trap", {31'd0, trap}, 32'd1);
    chk("tmo_memreq", {31'd0, mem_req}, 32'd0);
    chk_counters("tmo", 32'd8, 32'd0);

    // Ready arriving exactly at the timeout threshold wins.
    do_reset("rdywin");
    run = 1'b1; opcode = OP_R; mem_ready = 1'b0;
    step();
    repeat (7) step();
    chk("rdywin_stage_fetch", {29'd0, stage}, 32'd1);
    mem_ready = 1'b1;
    #1;
    chk("rdywin_ir_we", {31'd0, ir_we}, 32'd1);
    step();
    chk("rdywin_stage_decode", {29'd0, stage}, 32'd2);

    // Illegal opcode traps after DECODE; run toggling has no effect.
    do_reset("ill");
    run = 1'b1; opcode = OP_BAD; mem_ready = 1'b1;
    repeat (3) step();
    chk("ill_stage", {29'd0, stage}, 32'd7);
    chk("ill_outs", {24'd0, obs_outs()}, 32'h01);
    for (int i = 0; i < 3; i++) begin
      run = ~run;
      step();
      chk($sformatf("ill_hold%0d", i), {29'd0, stage}, 32'd7);
    end

    // SYSTEM opcode halts; run toggling has no effect.
    do_reset("halt");
    run = 1'b1; opcode = OP_SYS; mem_ready = 1'b1;
    repeat (3) step();
    chk("halt_stage", {29'd0, stage}, 32'd6);
    chk("halt_outs", {24'd0, obs_outs()}, 32'h02);
    for (int i = 0; i < 4; i++) begin
      run = ~run;
      step();
      chk($sformatf("halt_hold%0d", i), {29'd0, stage}, 32'd6);
    end
    chk_counters("halt", 32'd2, 32'd0);

    // Asynchronous reset in the middle of a stalled MEM access.
    do_reset("arst");
    run = 1'b1; opcode = OP_LD; dec_ruwr = 1'b1; mem_ready = 1'b1;
    repeat (3) step();
    mem_ready = 1'b0;
    step();
    chk("arst_pre_stage", {29'd0, stage}, 32'd4);
    chk("arst_pre_memreq", {31'd0, mem_req}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_memreq", {31'd0, mem_req}, 32'd0);
    chk("arst_stage", {29'd0, stage}, 32'd0);
    chk_counters("arst", 32'd0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
